fifo_get_scheduler: RTL and testbench
=====================================

// Module: fifo_get_scheduler
// PURPOSE
//  Round-robin scheduler sharing the FIFO get port among N_REQ consumers
//  (FIR channel engines). Pops one word per grant via fifo_req_get, waits the
//  FIFO read latency, then holds the word for the winning consumer until it acks.
//  Sits between FIFO_module's get side and the FIR datapath.
// PARAMETERS
//  N_BITS  32  data word width (matches FIFO)
//  N_REQ   4   number of consumers
//  IDX_W   2   consumer index width, = clog2(N_REQ), >=1
//  RD_LAT  2   cycles from fifo_req_get high to fifo_data_get valid, >=1
// PORTS
//  clk            in   1       single clock; all logic on rising edge
//  reset          in   1       asynchronous, active-high
//  req_in         in   N_REQ   level request per consumer
//  ack_in         in   N_REQ   one-cycle accept pulse per consumer
//  fifo_empty     in   1       FIFO empty_out
//  fifo_data_get  in   N_BITS  FIFO data_get
//  fifo_req_get   out  1       pop strobe to FIFO req_get
//  valid_out      out  N_REQ   one-hot: data_out valid for that consumer
//  data_out       out  N_BITS  registered popped word
//  grant_idx      out  IDX_W   index of current/last grantee
//  busy           out  1       high in any state but IDLE
// BEHAVIOUR
//  Reset: state=IDLE; fifo_req_get=0, valid_out=0, data_out=0, grant_idx=0,
//   busy=0, lat_cnt=0; rr_ptr=N_REQ-1 so consumer 0 wins first.
//  IDLE: if (|req_in) && !fifo_empty -> winner = first set req_in scanning
//   rr_ptr+1, rr_ptr+2, ... modulo N_REQ (wraps N_REQ-1 -> 0); register into
//   grant_idx; -> ISSUE. Otherwise stay. fifo_empty sampled only in IDLE.
//  ISSUE: fifo_req_get=1 for exactly this one cycle; lat_cnt<=RD_LAT-1; -> WAIT.
//  WAIT: if lat_cnt==0 capture fifo_data_get into data_out, -> DELIVER; else
//   decrement. Capture edge = RD_LAT cycles after the fifo_req_get cycle.
//  DELIVER: valid_out[grant_idx]=1, data_out stable. On ack_in[grant_idx]:
//   valid_out<=0, rr_ptr<=grant_idx, -> IDLE. ack_in on other bits ignored.
//  Throughput: one word per RD_LAT+3 cycles minimum (IDLE,ISSUE,WAIT..,DELIVER).
//  Fairness: a consumer holding req_in is granted within N_REQ transactions.
//  Simultaneous requests: lowest distance from rr_ptr+1 wins; others wait.
//  Request withdrawn after IDLE grant: transaction still completes; word held
//   in DELIVER until that consumer acks (no data loss, no re-grant).
//  Ack arriving same cycle valid_out rises counts; ack while not in DELIVER
//   ignored.
//  fifo_req_get never asserted in IDLE/WAIT/DELIVER; never two pops in flight.
//  Reset mid-operation: all state cleared as above; an already-popped word is
//   discarded (FIFO pointer already advanced; upstream tolerates the drop).
//  N_REQ=1: arbiter degenerates; grant_idx always 0.
// STRUCTURE
//  fir_fifo_defs.vh: state encodings (S_IDLE=2'd0, S_ISSUE=2'd1, S_WAIT=2'd2,
//   S_DELIVER=2'd3), shared N_BITS default; included by FIFO benches too.
//  Sub-module rr_arbiter #(N_REQ,IDX_W): combinational; inputs req, ptr;
//   outputs any, idx (rotate-priority). Remainder: FSM, lat_cnt, data reg.
// TESTING
//  T1 reset: assert reset async mid-cycle -> all outputs 0 immediately, busy=0.
//  T2 single: req_in=4'b0001, FIFO holds 32'hAAAAAAAA, RD_LAT=2 ->
//   fifo_req_get pulse 1 cycle, valid_out=4'b0001 with data_out=32'hAAAAAAAA
//   2 cycles later, cleared cycle after ack_in[0].
//  T3 round-robin: req_in=4'b1111 held, 8 words, immediate acks -> grant order
//   0,1,2,3,0,1,2,3; exactly 8 fifo_req_get pulses.
//  T4 empty: fifo_empty=1, req_in=4'b0110 -> no fifo_req_get, busy=0 for 20
//   cycles; drop fifo_empty -> grant_idx=1 served first.
//  T5 withdraw/late ack: consumer 2 drops req_in in WAIT, acks 10 cycles later ->
//   valid_out[2] held 10 cycles, data stable; ack_in[1] in between ignored.
//  T6 reset in WAIT: reset during WAIT -> no valid_out, next grant from idx 0.

Source files
------------

// File: rtl/fifo_get_scheduler_pkg.sv
// Purpose: shared state encoding and sizing helpers for the FIFO get-port scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_get_scheduler_pkg;

    // Encodings are fixed so FIFO-side benches can decode the state by value.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    localparam int N_BITS_DEF = 32;

    // Width of the read-latency down-counter; it only has to hold RD_LAT-1.
    function automatic int cnt_width(input int rd_lat);
        return (rd_lat > 1) ? $clog2(rd_lat) : 1;
    endfunction

endpackage

// File: rtl/fifo_get_scheduler_rr_arbiter.sv
// Purpose: rotate-priority pick of one requester, scanning ptr+1, ptr+2, ... modulo N_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module fifo_get_scheduler_rr_arbiter
    import fifo_get_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the farthest candidate to the nearest so the nearest set request overwrites.
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        o_any  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        for (int d = N_REQ; d >= 1; d--) begin
            w_cand = IDX_W'((int'(i_ptr) + d) % N_REQ);
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/fifo_get_scheduler.sv
// Purpose: shares the FIFO get port among N_REQ consumers, one popped word per grant, round-robin.
// Latency: grant to valid_out is RD_LAT+2 cycles; at least RD_LAT+3 cycles per word.
// Backpressure: the popped word is held in DELIVER until the granted consumer acks; no new pop meanwhile.
module fifo_get_scheduler
    import fifo_get_scheduler_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int N_REQ  = 4,
    parameter int IDX_W  = 2,
    parameter int RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_REQ-1:0]  i_req_in,
    input  logic [N_REQ-1:0]  i_ack_in,
    input  logic              i_fifo_empty,
    input  logic [N_BITS-1:0] i_fifo_data_get,
    output logic              o_fifo_req_get,
    output logic [N_REQ-1:0]  o_valid_out,
    output logic [N_BITS-1:0] o_data_out,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic              o_busy
);

    localparam int               CNT_W    = cnt_width(RD_LAT);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [IDX_W-1:0]  w_grant_nxt;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  w_rr_ptr_nxt;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [CNT_W-1:0]  w_lat_nxt;
    logic [N_BITS-1:0] r_data;
    logic [N_BITS-1:0] w_data_nxt;
    logic              w_arb_any;
    logic [IDX_W-1:0]  w_arb_idx;

    fifo_get_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req (i_req_in),
        .i_ptr (r_rr_ptr),
        .o_any (w_arb_any),
        .o_idx (w_arb_idx)
    );

    // Next-state logic: grant in IDLE, one-cycle pop in ISSUE, count out the FIFO latency, hold until ack.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant_idx;
        w_rr_ptr_nxt = r_rr_ptr;
        w_lat_nxt    = r_lat_cnt;
        w_data_nxt   = r_data;
        case (r_state)
            S_IDLE: begin
                // fifo_empty only matters here; once a pop is issued the word is committed.
                if (w_arb_any && !i_fifo_empty) begin
                    w_grant_nxt = w_arb_idx;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_lat_nxt   = LAT_LOAD;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_data_nxt  = i_fifo_data_get;
                    w_state_nxt = S_DELIVER;
                end else begin
                    w_lat_nxt = r_lat_cnt - 1'b1;
                end
            end
            S_DELIVER: begin
                // Only the grantee's ack releases the word; a withdrawn request does not.
                if (i_ack_in[r_grant_idx]) begin
                    w_rr_ptr_nxt = r_grant_idx;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, grant, rotation pointer, latency counter and data register; reset discards any popped word.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= PTR_RST;
            r_lat_cnt   <= '0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_data      <= w_data_nxt;
        end
    end

    // One-hot valid for the grantee, decoded straight from the registered state.
    always_comb begin
        o_valid_out = '0;
        if (r_state == S_DELIVER) begin
            o_valid_out[r_grant_idx] = 1'b1;
        end
    end

    assign o_fifo_req_get = (r_state == S_ISSUE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_data_out     = r_data;
    assign o_grant_idx    = r_grant_idx;

endmodule

// File: tb/tb_fifo_get_scheduler.sv
// Purpose: randomized scoreboard bench for fifo_get_scheduler against a queue-based FIFO and arbitration model.
// Latency: checks pop-to-valid latency of RD_LAT+1 cycles after the pop cycle.
// Backpressure: acks are delayed randomly; valid and data must hold until the grantee acks.
module tb_fifo_get_scheduler;

    localparam int N_BITS = 32;
    localparam int N_REQ  = 4;
    localparam int IDX_W  = 2;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_REQ-1:0]  req_in;
    logic [N_REQ-1:0]  ack_in;
    logic              fifo_empty;
    logic [N_BITS-1:0] fifo_data_get;
    logic              fifo_req_get;
    logic [N_REQ-1:0]  valid_out;
    logic [N_BITS-1:0] data_out;
    logic [IDX_W-1:0]  grant_idx;
    logic              busy;

    fifo_get_scheduler #(
        .N_BITS (N_BITS),
        .N_REQ  (N_REQ),
        .IDX_W  (IDX_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_req_in        (req_in),
        .i_ack_in        (ack_in),
        .i_fifo_empty    (fifo_empty),
        .i_fifo_data_get (fifo_data_get),
        .o_fifo_req_get  (fifo_req_get),
        .o_valid_out     (valid_out),
        .o_data_out      (data_out),
        .o_grant_idx     (grant_idx),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // FIFO model: storage written by the stimulus, popped on req_get, data appears RD_LAT cycles later.
    logic [N_BITS-1:0] mem [DEPTH];
    int                wr_n = 0;
    int                rd_n = 0;
    logic [N_BITS-1:0] pipe [RD_LAT];

    assign fifo_empty    = (wr_n == rd_n);
    assign fifo_data_get = pipe[RD_LAT-1];

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        if (fifo_req_get && (rd_n != wr_n)) begin
            pipe[0] <= mem[rd_n % DEPTH];
            rd_n    <= rd_n + 1;
        end else begin
            pipe[0] <= $urandom;
        end
    end

    // Scoreboard entries: expected grantee and word.
    typedef struct {
        int                idx;
        logic [N_BITS-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur  = 1'b0;
    bit   prev_get  = 1'b0;
    int   since_get = 1000;
    int   n_pops    = 0;

    // Monitor: counts pops, checks pop spacing and latency, compares every delivery cycle.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            have_cur  = 1'b0;
            prev_get  = 1'b0;
            since_get = 1000;
        end else begin
            if (fifo_req_get) begin
                n_pops++;
                check("single_pop", 64'(prev_get), 64'd0);
                check("busy_on_pop", 64'(busy), 64'd1);
                since_get = 0;
            end else begin
                since_get++;
            end
            prev_get = fifo_req_get;
            if (valid_out != '0) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'(valid_out), 64'd0);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        check("latency", 64'(since_get), 64'(RD_LAT + 1));
                    end
                end
                if (have_cur) begin
                    check("valid_onehot", 64'(valid_out), 64'd1 << cur.idx);
                    check("data_out", 64'(data_out), 64'(cur.data));
                    check("grant_idx", 64'(grant_idx), 64'(cur.idx));
                    check("busy_deliver", 64'(busy), 64'd1);
                end
            end else begin
                have_cur = 1'b0;
            end
        end
    end

    // Reference arbitration: first requester after the last one served, wrapping.
    int last_srv  = N_REQ - 1;
    int exp_pops  = 0;

    function automatic int pick(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic reset_outputs_check();
        check("rst_req_get", 64'(fifo_req_get), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next clock edge.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1 reset_outputs_check();
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        req_in   = '0;
        ack_in   = '0;
        last_srv = N_REQ - 1;
        @(negedge clk);
    endtask

    task automatic do_txn(input logic [N_REQ-1:0] r, input logic [N_BITS-1:0] word,
                          input int ack_dly, input bit withdraw, input int empty_cyc,
                          input bit wrong_ack, input bit rst_deliver);
        int               win;
        logic [N_REQ-1:0] oh;
        bit               seen;
        win    = pick(r, last_srv);
        oh     = N_REQ'(1) << win;
        req_in = r;
        for (int i = 0; i < empty_cyc; i++) begin
            @(negedge clk);
            check("empty_no_pop", 64'(fifo_req_get), 64'd0);
            check("empty_idle", 64'(busy), 64'd0);
        end
        mem[wr_n % DEPTH] = word;
        wr_n++;
        exp_pops++;
        exp_q.push_back('{idx: win, data: word});
        seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            if (withdraw && fifo_req_get) req_in[win] = 1'b0;
            if (valid_out[win]) seen = 1'b1;
        end
        check("grant_timeout", 64'(seen), 64'd1);
        if (!seen) begin
            req_in = '0;
            return;
        end
        if (rst_deliver) begin
            mid_reset();
            return;
        end
        for (int i = 0; i < ack_dly; i++) begin
            if (wrong_ack && i == 0) ack_in = ~oh;
            @(negedge clk);
            ack_in = '0;
            check("hold_valid", 64'(valid_out), 64'(oh));
        end
        ack_in = oh;
        req_in = '0;
        @(negedge clk);
        ack_in = '0;
        check("cleared_valid", 64'(valid_out), 64'd0);
        check("cleared_busy", 64'(busy), 64'd0);
        last_srv = win;
    endtask

    initial begin
        bit cyc_ok;
        reset  = 1'b1;
        req_in = '0;
        ack_in = '0;
        repeat (3) @(negedge clk);
        reset_outputs_check();
        reset = 1'b0;

        // Single consumer, known word.
        do_txn(4'b0001, 32'hAAAAAAAA, 1, 1'b0, 0, 1'b0, 1'b0);
        // Requests held while the FIFO is empty: nothing may be popped.
        do_txn(4'b0110, $urandom, 0, 1'b0, 20, 1'b0, 1'b0);
        // All requesting, immediate acks: strict rotation.
        for (int i = 0; i < 8; i++) do_txn(4'b1111, $urandom, 0, 1'b0, 0, 1'b0, 1'b0);
        // Withdraw during the wait, ack ten cycles late, foreign acks in between.
        do_txn(4'b0100, $urandom, 10, 1'b1, 0, 1'b1, 1'b0);

        // Reset while waiting on FIFO latency: the popped word is dropped.
        req_in            = 4'b1100;
        mem[wr_n % DEPTH] = $urandom;
        wr_n++;
        exp_pops++;
        exp_q.push_back('{idx: pick(4'b1100, last_srv), data: mem[(wr_n - 1) % DEPTH]});
        cyc_ok = 1'b0;
        for (int cyc = 0; cyc < 20 && !cyc_ok; cyc++) begin
            @(negedge clk);
            if (fifo_req_get) cyc_ok = 1'b1;
        end
        check("issue_timeout", 64'(cyc_ok), 64'd1);
        @(negedge clk);
        mid_reset();
        for (int i = 0; i < RD_LAT + 3; i++) begin
            @(negedge clk);
            check("no_valid_after_rst", 64'(valid_out), 64'd0);
        end
        do_txn(4'b1111, $urandom, 0, 1'b0, 0, 1'b0, 1'b0);

        // Reset while a word is being delivered.
        do_txn(4'b0010, $urandom, 0, 1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            do_txn(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom,
                   $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
                   ($urandom_range(0, 1) == 1), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("pop_count", 64'(n_pops), 64'(exp_pops));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
